// File: rtl/fix_pkg.sv
// Shared fixed-point definitions: default word format, saturation limits and
// the shift-and-saturate helper used by every fixed-point block.
package fix_pkg;

  localparam int FIX_DATA = 15;
  localparam int FIX_INTE = 6;
  localparam int FIX_POIN = 8;

  localparam logic [FIX_DATA-1:0] FIX_MAX = 15'h3FFF;
  localparam logic [FIX_DATA-1:0] FIX_MIN = 15'h4000;

  typedef struct packed {
    logic        ovf;
    logic [31:0] val;
  } sat_t;

  // Arithmetic shift right by pt (floor), then clamp to a dw-bit signed range.
  function automatic sat_t sat_shift(input logic signed [63:0] p, input int dw, input int pt);
    logic signed [63:0] q;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t r;
    q     = p >>> pt;
    hi    = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (dw - 1));
    r.ovf = 1'b0;
    r.val = q[31:0];
    if (q > hi) begin
      r.ovf = 1'b1;
      r.val = hi[31:0];
    end else if (q < lo) begin
      r.ovf = 1'b1;
      r.val = lo[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fix_mul_pipe.sv
// Fixed-latency signed multiply / shift / saturate pipeline carrying an
// opaque tag and a valid bit; no backpressure.
module fix_mul_pipe
  import fix_pkg::*;
#(
  parameter int DATA    = FIX_DATA,
  parameter int POIN    = FIX_POIN,
  parameter int TAG_W   = 2,
  parameter int MUL_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_vld,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic signed [DATA-1:0] in_a,
  input  logic signed [DATA-1:0] in_b,
  output logic                   out_vld,
  output logic [TAG_W-1:0]       out_tag,
  output logic [DATA-1:0]        out_data,
  output logic                   out_ovf,
  output logic                   busy
);

  localparam int PW = 2 * DATA;
  localparam int PL = (MUL_LAT > 2) ? MUL_LAT - 1 : 2;

  logic [MUL_LAT:1]        vld_d, vld_q;
  logic [TAG_W-1:0]        tag_d [1:MUL_LAT];
  logic [TAG_W-1:0]        tag_q [1:MUL_LAT];
  logic signed [PW-1:0]    a_p1_d, a_p1_q, b_p1_d, b_p1_q;
  logic signed [PW-1:0]    prod_d [2:PL];
  logic signed [PW-1:0]    prod_q [2:PL];
  logic signed [PW-1:0]    prod_fin;
  sat_t                    sat;
  logic [DATA-1:0]         data_d, data_q;
  logic                    ovf_d, ovf_q;
  logic                    busy_d, busy_q;

  // Data registers only load behind a valid op, so idle outputs hold steady.
  always_comb begin
    vld_d    = {vld_q[MUL_LAT-1:1], in_vld};
    tag_d[1] = in_tag;
    for (int k = 2; k <= MUL_LAT; k++) tag_d[k] = tag_q[k-1];

    // stage 1: sign-extended operands
    a_p1_d = in_vld ? PW'(in_a) : a_p1_q;
    b_p1_d = in_vld ? PW'(in_b) : b_p1_q;

    // stage 2: full-width product, then optional delay stages
    prod_d[2] = vld_q[1] ? a_p1_q * b_p1_q : prod_q[2];
    for (int k = 3; k <= PL; k++) prod_d[k] = vld_q[k-1] ? prod_q[k-1] : prod_q[k];

    // final stage: shift and saturate
    prod_fin = (MUL_LAT == 2) ? a_p1_q * b_p1_q : prod_q[PL];
    sat      = sat_shift(64'(prod_fin), DATA, POIN);
    data_d   = vld_q[MUL_LAT-1] ? sat.val[DATA-1:0] : data_q;
    ovf_d    = vld_q[MUL_LAT-1] ? sat.ovf : ovf_q;
    busy_d   = |vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      a_p1_q <= '0;
      b_p1_q <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      for (int k = 1; k <= MUL_LAT; k++) tag_q[k] <= '0;
      for (int k = 2; k <= PL; k++) prod_q[k] <= '0;
    end else begin
      vld_q  <= vld_d;
      a_p1_q <= a_p1_d;
      b_p1_q <= b_p1_d;
      data_q <= data_d;
      ovf_q  <= ovf_d;
      busy_q <= busy_d;
      for (int k = 1; k <= MUL_LAT; k++) tag_q[k] <= tag_d[k];
      for (int k = 2; k <= PL; k++) prod_q[k] <= prod_d[k];
    end
  end

  assign out_vld  = vld_q[MUL_LAT];
  assign out_tag  = tag_q[MUL_LAT];
  assign out_data = data_q;
  assign out_ovf  = ovf_q;
  assign busy     = busy_q;

endmodule

// File: rtl/fix_mul_arb.sv
// Round-robin arbiter sharing one fixed-point multiplier pipeline among NREQ
// requesters; results return one-hot to the requester that issued them.
module fix_mul_arb
  import fix_pkg::*;
#(
  parameter int DATA    = FIX_DATA,
  parameter int INTE    = FIX_INTE,
  parameter int POIN    = FIX_POIN,
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*DATA-1:0]      req_a,
  input  logic [NREQ*DATA-1:0]      req_b,
  input  logic [NREQ-1:0]           req_mask,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [DATA-1:0]           rsp_data,
  output logic                      rsp_ovf,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic                      busy
);

  localparam int ID_W = $clog2(NREQ);

  if (DATA != 1 + INTE + POIN || NREQ < 2 || NREQ > 8 || MUL_LAT < 2) begin : g_bad_cfg
    $error("fix_mul_arb: unsupported parameter set");
  end

  logic [NREQ-1:0]        elig, gnt;
  logic [ID_W-1:0]        gnt_idx;
  logic [ID_W-1:0]        rr_ptr_d, rr_ptr_q;
  logic signed [DATA-1:0] mux_a, mux_b;
  logic                   pipe_vld;
  logic [ID_W-1:0]        pipe_id;

  // Scan from farthest to nearest so the first eligible bit at/after rr_ptr wins.
  always_comb begin
    int idx;
    idx     = 0;
    elig    = req_valid & req_mask;
    gnt     = '0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (elig[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx[ID_W-1:0];
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (|gnt) rr_ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
    mux_a = req_a[int'(gnt_idx)*DATA +: DATA];
    mux_b = req_b[int'(gnt_idx)*DATA +: DATA];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  assign req_ready = gnt;

  fix_mul_pipe #(
    .DATA    (DATA),
    .POIN    (POIN),
    .TAG_W   (ID_W),
    .MUL_LAT (MUL_LAT)
  ) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (|gnt),
    .in_tag   (gnt_idx),
    .in_a     (mux_a),
    .in_b     (mux_b),
    .out_vld  (pipe_vld),
    .out_tag  (pipe_id),
    .out_data (rsp_data),
    .out_ovf  (rsp_ovf),
    .busy     (busy)
  );

  always_comb begin
    rsp_valid          = '0;
    rsp_valid[pipe_id] = pipe_vld;
  end

  assign rsp_id = pipe_id;

endmodule

// File: doc/fix_mul_arb.md
# fix_mul_arb

Round-robin arbiter and pipeline sequencer that shares one signed fixed-point multiplier among `NREQ` requesters. It sits between the fixed-point arithmetic users (filters, accumulators) and the multiplier datapath. It accepts at most one operand pair per cycle and tags each pair with its requester ID through a fixed-latency multiply pipeline. It returns a saturated, tagged product one-hot to the owning requester.

## Interface
Parameters:
- `DATA`, 15, word width; signed two's complement, 1 sign + `INTE` integer + `POIN` fraction bits
- `INTE`, 6, integer bits
- `POIN`, 8, fraction bits
- `NREQ`, 4, number of requesters (2..8)
- `MUL_LAT`, 3, multiplier pipeline depth in cycles (≥2)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  per-requester operand valid
- `req_ready`  out  NREQ  one-hot grant; transfer on `req_valid[i] & req_ready[i]`
- `req_a`  in  NREQ*DATA  packed operand A, requester i at `[i*DATA +: DATA]`
- `req_b`  in  NREQ*DATA  packed operand B
- `req_mask`  in  NREQ  1 = requester eligible; 0 = never granted
- `rsp_valid`  out  NREQ  one-hot, one-cycle result strobe
- `rsp_data`  out  DATA  product, shared by all requesters
- `rsp_ovf`  out  1  saturation occurred on this result
- `rsp_id`  out  $clog2(NREQ)  requester index of current result
- `busy`  out  1  any pipeline stage holds a valid op

## Operation
- Eligible set E = `req_valid & req_mask`. If E is nonzero, grant exactly one bit: the first set bit at or above `rr_ptr`, wrapping around. Grant is combinational from E and `rr_ptr`.
- `req_ready` is nonzero only for the granted bit. Requesters must hold `req_valid` and operands stable until granted.
- On a transfer, `rr_ptr` becomes granted index + 1 (mod NREQ). With no transfer, `rr_ptr` holds.
- Pipeline: `MUL_LAT` stages, each holding {valid, id, data}. There is no backpressure; responses cannot be stalled.
- Stage 1 captures sign-extended A, B, and the id. Stage 2 forms the full 2*DATA signed product P = A*B.
- The final stage computes Q = P >>> POIN (arithmetic shift, truncation toward −inf).
- Saturation: if Q > 2^(DATA−1)−1, the output is 0x3FFF with ovf = 1. If Q < −2^(DATA−1), the output is 0x4000 with ovf = 1. Otherwise the output is Q[DATA−1:0] with ovf = 0.
- `rsp_valid[rsp_id]` = last-stage valid; all other `rsp_valid` bits are 0. When no valid result is present, `rsp_data`, `rsp_ovf` and `rsp_id` are don't-care but must not be X.
- The arbiter has no state machine beyond `rr_ptr` and the stage valid bits.

## Timing
- Reset (async assert, sync deassert by the system):
  - `rr_ptr` = 0
  - all stage valids = 0
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_ovf` = 0, `rsp_id` = 0, `busy` = 0
  - `req_ready` is driven purely by E and is therefore live during reset.
- Reset mid-operation discards all in-flight ops. No `rsp_valid` is produced for them after reset.
- Latency: transfer in cycle T gives `rsp_valid` high for exactly cycle T+MUL_LAT.
- Throughput: one op per cycle. Back-to-back transfers produce back-to-back responses in grant order.
- Simultaneous requests: requesters are served in rotating order. Each continuously requesting, unmasked requester is granted at least once every NREQ cycles.
- A request whose mask bit is cleared while pending is not granted. Ops from that requester already in the pipeline still complete.
- `busy` is the OR of stage valids, registered with the stages. It falls in the cycle after the last `rsp_valid`.

## Structure
- Shared package `fix_pkg`:
  - DATA/INTE/POIN defaults
  - `FIX_MAX` = 15'h3FFF, `FIX_MIN` = 15'h4000
  - saturate-and-shift function used by all fixed-point blocks
- One sub-module: `fix_mul_pipe`, the `MUL_LAT`-stage signed multiply/shift/saturate datapath. It carries an opaque tag and a valid bit.
- The round-robin grant logic lives in `fix_mul_arb`.

## Test plan
- Single op, requester 0: A=0x0100 (1.0), B=0x0280 (2.5). Expect `rsp_valid`=4'b0001 exactly 3 cycles later, data 0x0280, ovf 0.
- Negative: requester 2, A=0x7E80 (−1.5), B=0x0200 (2.0). Expect data 0x7D00 (−3.0), `rsp_id`=2, ovf 0.
- Saturation:
  - 0x3FFF×0x3FFF gives 0x3FFF with ovf 1.
  - 0x3FFF×0x4000 gives 0x4000 with ovf 1.
- All four requesters valid continuously from reset. Expect grants 0,1,2,3,0,… one per cycle, and responses in the same order with the same per-cycle spacing.
- `req_mask`=4'b1010 with all requesting. Expect only 1 and 3 granted, alternating. Clearing mask bit 3 mid-stream leaves only 1, and in-flight ops for 3 still return.
- Assert `rst_n` low with 3 ops in flight. Expect `rsp_valid` and `busy` = 0 immediately and no response after release; the first grant afterward goes to the lowest eligible index.
